// File: rtl/maze_pkg.sv
// Shared maze definitions: direction codes, wall bit positions, carver states.
// Imported by the carver, the renderer and the player-move logic.
package maze_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam int WALL_EAST  = 0;
  localparam int WALL_SOUTH = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INIT,
    ST_STEP,
    ST_DONE
  } maze_state_e;

  function automatic int cell_idx_w(input int n_cells);
    return (n_cells > 1) ? $clog2(n_cells) : 1;
  endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
// Steps every cycle; reset reloads SEED.
module maze_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_out
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_out = lfsr_q;

endmodule

// File: rtl/maze_carver.sv
// Randomized depth-first backtracker carving a perfect maze into per-cell
// east/south wall bits, with a registered write-first read port.
module maze_carver
  import maze_pkg::*;
#(
  parameter int          W    = 16,
  parameter int          H    = 12,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 carve,
  output logic                 finished_carve,
  output logic                 busy,
  input  logic [$clog2(W)-1:0] rd_x,
  input  logic [$clog2(H)-1:0] rd_y,
  output logic [1:0]           rd_walls
);

  localparam int N  = W * H;
  localparam int CW = cell_idx_w(N);
  localparam int SW = $clog2(N + 1);

  maze_state_e   state_q, state_d;
  logic          carve_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sp_q, sp_d;
  logic [N-1:0]  visited_q, visited_d;
  logic [N-1:0]  east_q, east_d;
  logic [N-1:0]  south_q, south_d;
  logic [1:0]    rd_walls_q, rd_walls_d;

  logic [CW-1:0] stack_mem [N];
  logic          stack_we;
  logic [CW-1:0] stack_wa, stack_wd;

  logic [15:0]   lfsr;
  logic [1:0]    r;
  logic          unused_lfsr;

  logic [CW-1:0] top, top_x, top_y, nbr;
  logic [CW-1:0] nb [4];
  logic [3:0]    mask;
  logic [1:0]    dir, cand;
  logic          found;

  logic [CW-1:0] rd_idx;
  logic          rd_ok;

  maze_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .lfsr_out (lfsr)
  );

  assign r           = lfsr[1:0];
  assign unused_lfsr = ^lfsr[15:2];

  // Top-of-stack cell, its in-bounds unvisited neighbours, and the random pick.
  always_comb begin
    top   = stack_mem[CW'(sp_q - 1'b1)];
    top_x = top % CW'(W);
    top_y = top / CW'(W);
    nb[DIR_N] = top - CW'(W);
    nb[DIR_E] = top + 1'b1;
    nb[DIR_S] = top + CW'(W);
    nb[DIR_W] = top - 1'b1;
    mask = '0;
    mask[DIR_N] = (top_y != '0)         && !visited_q[nb[DIR_N]];
    mask[DIR_E] = (top_x != CW'(W - 1)) && !visited_q[nb[DIR_E]];
    mask[DIR_S] = (top_y != CW'(H - 1)) && !visited_q[nb[DIR_S]];
    mask[DIR_W] = (top_x != '0)         && !visited_q[nb[DIR_W]];
    dir   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = r + 2'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        dir   = cand;
      end
    end
    nbr = nb[dir];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sp_d      = sp_q;
    visited_d = visited_q;
    east_d    = east_q;
    south_d   = south_q;
    stack_we  = 1'b0;
    stack_wa  = '0;
    stack_wd  = '0;
    case (state_q)
      ST_IDLE: begin
        if (carve && !carve_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        east_d[cnt_q]    = 1'b1;
        south_d[cnt_q]   = 1'b1;
        visited_d[cnt_q] = 1'b0;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = ST_INIT;
      end
      ST_INIT: begin
        visited_d[0] = 1'b1;
        stack_we     = 1'b1;
        sp_d         = SW'(1);
        state_d      = ST_STEP;
      end
      ST_STEP: begin
        if (mask != 4'b0000) begin
          // West/north walls live in the neighbour's east/south bit.
          case (dir)
            DIR_N:   south_d[nbr] = 1'b0;
            DIR_E:   east_d[top]  = 1'b0;
            DIR_S:   south_d[top] = 1'b0;
            default: east_d[nbr]  = 1'b0;
          endcase
          visited_d[nbr] = 1'b1;
          stack_we       = 1'b1;
          stack_wa       = CW'(sp_q);
          stack_wd       = nbr;
          sp_d           = sp_q + 1'b1;
        end else begin
          sp_d = sp_q - 1'b1;
          if (sp_d == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-first read: the port sees this cycle's wall update.
  always_comb begin
    rd_idx     = CW'(rd_y) * CW'(W) + CW'(rd_x);
    rd_ok      = (int'(rd_x) < W) && (int'(rd_y) < H);
    rd_walls_d = rd_ok ? {south_d[rd_idx], east_d[rd_idx]} : 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      carve_q    <= 1'b0;
      cnt_q      <= '0;
      sp_q       <= '0;
      rd_walls_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      carve_q    <= carve;
      cnt_q      <= cnt_d;
      sp_q       <= sp_d;
      rd_walls_q <= rd_walls_d;
      visited_q  <= visited_d;
      east_q     <= east_d;
      south_q    <= south_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && stack_we) stack_mem[stack_wa] <= stack_wd;
  end

  always_comb begin
    busy           = (state_q != ST_IDLE);
    finished_carve = (state_q == ST_DONE);
  end

  assign rd_walls = rd_walls_q;

endmodule

// File: tb/tb_maze_carver.sv
// Directed bench for maze_carver (4x3): timing, reference-model maps,
// spanning-tree properties, reset aborts and the write-first read port.
module tb_maze_carver;

  localparam int          W    = 4;
  localparam int          H    = 3;
  localparam int          N    = W * H;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       carve = 1'b0;
  logic [1:0] rd_x = 2'd0;
  logic [1:0] rd_y = 2'd0;
  logic       finished_carve, busy;
  logic [1:0] rd_walls;

  int total = 0;
  int bad   = 0;

  logic [15:0]      m_lfsr;
  logic [2*N-1:0]   exp_map_q [$];
  int               exp_done_q [$];

  maze_carver #(.W(W), .H(H), .SEED(SEED)) dut (
    .clk            (clk),
    .rst            (rst),
    .carve          (carve),
    .finished_carve (finished_carve),
    .busy           (busy),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_walls       (rd_walls)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
  endfunction

  always @(posedge clk) m_lfsr <= rst ? SEED : lstep(m_lfsr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference backtracker; l0 is the LFSR value in the start-sample cycle.
  task automatic model_carve(input logic [15:0] l0, output logic [2*N-1:0] map,
                             output int clr_step, output int clr_bit);
    logic [N-1:0] vis;
    logic [15:0]  l;
    logic [3:0]   m;
    int stk [N];
    int nb [4];
    int sp, s, top, tx, ty, d, ch;
    map = '1; vis = '0; l = l0; clr_step = -1; clr_bit = 0;
    for (int j = 0; j < N + 2; j++) l = lstep(l);
    vis[0] = 1'b1; stk[0] = 0; sp = 1; s = 0;
    while (sp > 0) begin
      top = stk[sp-1]; tx = top % W; ty = top / W;
      nb[0] = top - W; nb[1] = top + 1; nb[2] = top + W; nb[3] = top - 1;
      m = '0;
      if (ty > 0)     m[0] = !vis[nb[0]];
      if (tx < W - 1) m[1] = !vis[nb[1]];
      if (ty < H - 1) m[2] = !vis[nb[2]];
      if (tx > 0)     m[3] = !vis[nb[3]];
      ch = -1;
      for (int k = 0; k < 4; k++) begin
        d = (int'(l[1:0]) + k) % 4;
        if (ch < 0 && m[d]) ch = d;
      end
      if (ch >= 0) begin
        case (ch)
          0: map[2*nb[0]+1] = 1'b0;
          1: map[2*top]     = 1'b0;
          2: map[2*top+1]   = 1'b0;
          default: map[2*nb[3]] = 1'b0;
        endcase
        if (clr_step < 0 && ((ch == 1 && top == 0) || (ch == 2 && top == 0) ||
                             (ch == 3 && nb[3] == 0) || (ch == 0 && nb[0] == 0))) begin
          clr_step = s;
          clr_bit  = (ch == 1 || ch == 3) ? 0 : 1;
        end
        vis[nb[ch]] = 1'b1; stk[sp] = nb[ch]; sp++;
      end else begin
        sp--;
      end
      l = lstep(l); s++;
    end
  endtask

  function automatic int find_root(input int p [N], input int a);
    int x = a;
    while (p[x] != x) x = p[x];
    return x;
  endfunction

  task automatic tree_check(input logic [2*N-1:0] map);
    int par [N];
    int walls, merges, loops, i, ra, rb;
    walls = 0; merges = 0; loops = 0;
    for (int k = 0; k < N; k++) par[k] = k;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        i = y * W + x;
        for (int dd = 0; dd < 2; dd++) begin
          if ((dd == 0 && x < W - 1) || (dd == 1 && y < H - 1)) begin
            if (map[2*i+dd]) walls++;
            else begin
              ra = find_root(par, i);
              rb = find_root(par, (dd == 0) ? i + 1 : i + W);
              if (ra == rb) loops++;
              else begin par[ra] = rb; merges++; end
            end
          end
        end
      end
    chk("interior_walls", walls, 17 - (N - 1));
    chk("reachable_merges", merges, N - 1);
    chk("no_cycle", loops, 0);
  endtask

  task automatic read_map(output logic [2*N-1:0] map);
    map = '0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_x = 2'(i % W);
      rd_y = 2'(i / W);
      @(negedge clk);
      map[2*i +: 2] = rd_walls;
    end
  endtask

  task automatic do_carve(input int quiet, output logic [2*N-1:0] got,
                          output logic [2*N-1:0] em);
    int  cs, cb, exp_c, pulses;
    bit  seen;
    @(negedge clk);
    model_carve(m_lfsr, em, cs, cb);
    exp_map_q.push_back(em);
    exp_done_q.push_back(3 * N + 1);
    rd_x = 2'd0; rd_y = 2'd0; carve = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 3 * N + 10 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_at_k1", busy, 1);
      if (c == N + 2 + cs) chk("rd_before_clear", rd_walls[cb], 1);
      if (c == N + 3 + cs) chk("rd_after_clear", rd_walls[cb], 0);
      if (finished_carve) begin
        seen  = 1'b1;
        exp_c = exp_done_q.pop_front();
        chk("done_cycle", c, exp_c);
        chk("busy_in_done", busy, 1);
      end
    end
    chk("done_seen", seen, 1);
    if (!seen) void'(exp_done_q.pop_front());
    @(negedge clk);
    chk("busy_fall", busy, 0);
    pulses = 0;
    for (int j = 0; j < quiet; j++) begin
      @(negedge clk);
      if (finished_carve || busy) pulses++;
    end
    chk("no_second_pulse", pulses, 0);
    carve = 1'b0;
    read_map(got);
    chk("map_vs_model", got, exp_map_q.pop_front());
    tree_check(got);
  endtask

  task automatic do_abort(input int at);
    int pulses = 0;
    @(negedge clk);
    carve = 1'b1;
    for (int c = 1; c < at; c++) begin
      @(negedge clk);
      if (finished_carve) pulses++;
    end
    @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_finished", finished_carve, 0);
    rst = 1'b0;
    carve = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (finished_carve || busy) pulses++;
    end
    chk("abort_quiet", pulses, 0);
  endtask

  task automatic reset_and_idle();
    int act = 0;
    rst = 1'b1; carve = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_finished", finished_carve, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_walls", rd_walls, 2'b00);
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (busy || finished_carve) act++;
    end
    chk("idle_no_busy", act, 0);
  endtask

  initial begin
    logic [2*N-1:0] map_a, map_b, map_c, map_d;
    logic [2*N-1:0] em_a, em_b, em_c, em_d;

    reset_and_idle();
    do_carve(100, map_a, em_a);

    repeat (7) @(negedge clk);
    do_carve(10, map_b, em_b);
    if (em_a != em_b) chk("gap_changes_map", (map_a != map_b), 1);

    reset_and_idle();
    do_carve(100, map_c, em_c);
    chk("repeat_identical", map_c, map_a);

    do_abort(4);
    do_abort(N + 7);
    repeat (3) @(negedge clk);
    do_carve(10, map_d, em_d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
